// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
//
// Purpose:
//   Sole read-side consumer of the synchronous FIFO (registered read data,
//   one-cycle read latency). Pops DATA_WIDTH-bit words and emits them as a
//   byte stream on a valid/ready master interface. m_last flags the final
//   byte of each word.
//
// Build option:
//   SER_MSB_FIRST_EN - when defined, bytes leave most-significant first.
//                      By default they leave least-significant first.
//                      Timing, handshake and counters are the same in both builds.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data, valid the cycle after a pop
//   fifo_cs     FIFO chip select, always equal to fifo_rd_en
//   fifo_rd_en  FIFO read request, one-cycle pulse per word
//   m_valid     byte valid
//   m_data      byte data
//   m_last      final byte of the current word
//   m_ready     sink ready; a byte transfers on m_valid && m_ready
//   busy        high whenever the controller is not IDLE
//   word_cnt    number of fully transmitted words (wraps)

module fifo_byte_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTES      = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [7:0]            m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      next_idx;

    assign next_idx = idx + 1'b1;

    // The chip select and read enable are the same pulse.
    assign fifo_cs = fifo_rd_en;
    assign busy    = (state != IDLE);

    // Byte k of a word in transmission order.
    function automatic logic [7:0] get_byte(input logic [DATA_WIDTH-1:0] w,
                                            input logic [IDX_W-1:0]      k);
`ifdef SER_MSB_FIRST_EN
        get_byte = w[DATA_WIDTH-1-8*int'(k) -: 8];
`else
        get_byte = w[8*int'(k) +: 8];
`endif
    endfunction

    // Controller: IDLE -> REQ (pop) -> CAP (data arrives) -> SEND (bytes out).
    // m_data/m_last are loaded one byte ahead, so they only change on a
    // handshake edge and stay stable while the sink stalls. After the last
    // byte the controller goes straight to REQ if more words are waiting,
    // giving BYTES+2 cycles per word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= 8'h00;
            m_last     <= 1'b0;
            word_cnt   <= '0;
            word_reg   <= '0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= REQ;
                        fifo_rd_en <= 1'b1;
                    end
                end

                REQ: begin
                    state      <= CAP;
                    fifo_rd_en <= 1'b0;
                end

                // FIFO read data is valid during this cycle.
                CAP: begin
                    word_reg <= fifo_data;
                    idx      <= '0;
                    m_valid  <= 1'b1;
                    m_data   <= get_byte(fifo_data, '0);
                    m_last   <= 1'b0;
                    state    <= SEND;
                end

                SEND: begin
                    if (m_ready) begin
                        if (idx == LAST_IDX) begin
                            word_cnt <= word_cnt + 1'b1;
                            m_valid  <= 1'b0;
                            m_data   <= 8'h00;
                            m_last   <= 1'b0;
                            if (!fifo_empty) begin
                                state      <= REQ;
                                fifo_rd_en <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx    <= next_idx;
                            m_data <= get_byte(word_reg, next_idx);
                            m_last <= (next_idx == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer
//
// Bench for fifo_byte_serializer. A small FIFO model feeds the DUT with
// registered read data; every word loaded pushes its expected bytes into a
// scoreboard queue, and a monitor pops and compares on each handshake.
// Define SER_MSB_FIRST_EN for both files to exercise the MSB-first build.

module tb_fifo_byte_serializer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_cs;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fifo_byte_serializer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_cs    (fifo_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: pointers written by separate processes, registered read.
    logic [DW-1:0] mem [0:63];
    logic [5:0]    wr_ptr = '0;
    logic [5:0]    rd_ptr = '0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_cs && fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb [$];
    int   hs_cyc [$];
    int   rd_cyc [$];
    int   hs_count = 0;
    int   rd_count = 0;

    typedef struct {
        logic [DW-1:0]   word;
        logic [3:0][7:0] bytes;
    } vec_t;

    vec_t vecs [3];

    function automatic void checkOutput(input string name,
                                        input logic [31:0] actual,
                                        input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endfunction

    // Monitor at the falling edge: values here are what the next rising
    // edge will see, so a valid && ready pair here is a handshake.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(m_valid), 32'd1);
                checkOutput("hold_data", 32'(m_data), 32'(prev_data));
                checkOutput("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (fifo_rd_en) begin
                rd_count++;
                rd_cyc.push_back(cyc);
                checkOutput("rd_when_nonempty", 32'(fifo_empty), 32'd0);
                checkOutput("cs_eq_rd_en", 32'(fifo_cs), 32'd1);
            end
            if (m_valid && m_ready) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("byte_data", 32'(m_data), 32'(e.data));
                    checkOutput("byte_last", 32'(m_last), 32'(e.last));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one word into the FIFO model and queue its bytes in emission order.
    task automatic applyStimulus(input logic [DW-1:0] word,
                                 input logic [3:0][7:0] bytes);
        mem[wr_ptr] = word;
        wr_ptr = wr_ptr + 6'd1;
        for (int k = 0; k < 4; k++) begin
            int src;
`ifdef SER_MSB_FIRST_EN
            src = 3 - k;
`else
            src = k;
`endif
            sb.push_back(exp_t'{data: bytes[src], last: (k == 3)});
        end
    endtask

    // Run until all queued bytes are out and the DUT is idle, driving
    // m_ready from a 4-cycle pattern (bit 0 first).
    task automatic waitIdle(input string name, input int max_cycles,
                            input logic [3:0] ready_pat);
        int         n;
        logic [1:0] ph;
        n  = 0;
        ph = 2'd0;
        while ((sb.size() != 0 || busy || !fifo_empty) && n < max_cycles) begin
            m_ready = ready_pat[ph];
            ph = ph + 2'd1;
            tick();
            n++;
        end
        m_ready = 1'b1;
        n_checks++;
        if (n >= max_cycles) begin
            n_errors++;
            $display("[TB] FAIL timeout_%s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    initial begin
        int hs0;
        int rd0;
        int n;

        vecs[0] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[1] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{32'hFFFFFF00, {8'hFF, 8'hFF, 8'hFF, 8'h00}};

        // Reset held for two edges with a word waiting.
        $display("[TB] reset");
        m_ready = 1'b1;
        applyStimulus(32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
            checkOutput("rst_m_data", 32'(m_data), 32'd0);
            checkOutput("rst_m_last", 32'(m_last), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
            checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            checkOutput("rst_cs", 32'(fifo_cs), 32'd0);
        end
        checkOutput("rst_no_rd_pulse", 32'(rd_count), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("release_rd_en", 32'(fifo_rd_en), 32'd1);
        checkOutput("release_busy", 32'(busy), 32'd1);

        // Single word, sink always ready.
        $display("[TB] single word");
        waitIdle("single", 40, 4'b1111);
        checkOutput("single_word_cnt", 32'(word_cnt), 32'd1);
        checkOutput("single_rd_pulses", 32'(rd_count), 32'd1);
        checkOutput("single_handshakes", 32'(hs_count), 32'd4);
        checkOutput("single_busy", 32'(busy), 32'd0);
        checkOutput("single_consecutive", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
        checkOutput("single_latency", 32'(hs_cyc[0] - rd_cyc[0]), 32'd2);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        $display("[TB] backpressure");
        hs0 = hs_count;
        applyStimulus(32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11});
        waitIdle("backpressure", 60, 4'b1001);
        checkOutput("bp_handshakes", 32'(hs_count - hs0), 32'd4);
        checkOutput("bp_word_cnt", 32'(word_cnt), 32'd2);

        // Back-to-back words.
        $display("[TB] back-to-back");
        hs0 = hs_count;
        rd0 = rd_count;
        hs_cyc.delete();
        rd_cyc.delete();
        applyStimulus(32'hA0A1A2A3, {8'hA0, 8'hA1, 8'hA2, 8'hA3});
        applyStimulus(32'hB0B1B2B3, {8'hB0, 8'hB1, 8'hB2, 8'hB3});
        waitIdle("b2b", 60, 4'b1111);
        checkOutput("b2b_word_cnt", 32'(word_cnt), 32'd4);
        checkOutput("b2b_handshakes", 32'(hs_count - hs0), 32'd8);
        checkOutput("b2b_rd_pulses", 32'(rd_count - rd0), 32'd2);
        if (hs_cyc.size() == 8 && rd_cyc.size() == 2) begin
            checkOutput("b2b_second_rd", 32'(rd_cyc[1] - hs_cyc[3]), 32'd1);
            checkOutput("b2b_gap", 32'(hs_cyc[4] - hs_cyc[3]), 32'd3);
            checkOutput("b2b_word2_span", 32'(hs_cyc[7] - hs_cyc[4]), 32'd3);
        end else begin
            checkOutput("b2b_event_count", 32'(hs_cyc.size()), 32'd8);
        end

        // Table of further words.
        $display("[TB] vector table");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].word, vecs[i].bytes);
            waitIdle("vector", 40, 4'b1111);
            checkOutput("vec_word_cnt", 32'(word_cnt), 32'(5 + i));
        end

        // Empty FIFO for 50 cycles.
        $display("[TB] empty fifo");
        rd0 = rd_count;
        for (int i = 0; i < 50; i++) begin
            tick();
            checkOutput("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            checkOutput("empty_m_valid", 32'(m_valid), 32'd0);
            checkOutput("empty_busy", 32'(busy), 32'd0);
        end
        checkOutput("empty_rd_pulses", 32'(rd_count - rd0), 32'd0);

        // Reset after the second byte handshake.
        $display("[TB] reset mid-send");
        hs0 = hs_count;
        applyStimulus(32'h13579BDF, {8'h13, 8'h57, 8'h9B, 8'hDF});
        n = 0;
        while ((hs_count - hs0) < 2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("midrst_reached_2", 32'(hs_count - hs0), 32'd2);
        rst_n = 1'b0;
        tick();
        sb.delete();
        checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("midrst_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_no_more_bytes", 32'(hs_count - hs0), 32'd2);
        checkOutput("midrst_idle_rd_en", 32'(fifo_rd_en), 32'd0);
        applyStimulus(32'h0A0B0C0D, {8'h0A, 8'h0B, 8'h0C, 8'h0D});
        waitIdle("after_reset", 40, 4'b1111);
        checkOutput("midrst_word_cnt_after", 32'(word_cnt), 32'd1);
        checkOutput("midrst_handshakes_after", 32'(hs_count - hs0), 32'd6);
        checkOutput("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
